// File: rtl/e_m_pipe_reg_pkg.sv
// rtl/e_m_pipe_reg_pkg.sv - shared constants for the E/M pipeline register and exception merge
package e_m_pipe_reg_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MDU = 2'd1;
    localparam logic [1:0] RES_PC8 = 2'd2;

    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/e_m_pipe_reg_exc_merge.sv
// rtl/e_m_pipe_reg_exc_merge.sv - em_exc_merge: priority exception merge and write suppression
module em_exc_merge
    import e_m_pipe_reg_pkg::*;
(
    input  logic [4:0] exc_i,
    input  logic       alu_ov_i,
    input  logic       is_load_i,
    input  logic       is_store_i,
    input  logic [4:0] wa_i,
    output logic [4:0] exc_o,
    output logic [4:0] wa_o,
    output logic       is_load_o,
    output logic       is_store_o
);

    always_comb begin
        exc_o = EXC_NONE;
        // An exception from an earlier stage always outranks the E-stage ones.
        if (exc_i != EXC_NONE) begin
            exc_o = exc_i;
        end else if (alu_ov_i && is_load_i) begin
            exc_o = EXC_ADEL;
        end else if (alu_ov_i && is_store_i) begin
            exc_o = EXC_ADES;
        end else if (alu_ov_i) begin
            exc_o = EXC_OV;
        end

        wa_o       = wa_i;
        is_load_o  = is_load_i;
        is_store_o = is_store_i;
        // A faulting instruction must not write a GPR or touch memory.
        if (exc_o != EXC_NONE) begin
            wa_o       = 5'd0;
            is_load_o  = 1'b0;
            is_store_o = 1'b0;
        end
    end

endmodule

// File: rtl/e_m_pipe_reg.sv
// rtl/e_m_pipe_reg.sv - E/M pipeline register; EM_PERF_CNT_EN adds the m_perf_md MDU-read counter
module e_m_pipe_reg
    import e_m_pipe_reg_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
    parameter int          TNEW_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              en,
    input  logic [31:0]       e_pc,
    input  logic [31:0]       e_instr,
    input  logic [31:0]       e_alu_res,
    input  logic              e_alu_ov,
    input  logic [31:0]       e_mdu_res,
    input  logic [1:0]        e_res_sel,
    input  logic [31:0]       e_rt_data,
    input  logic [4:0]        e_wa,
    input  logic [TNEW_W-1:0] e_tnew,
    input  logic [4:0]        e_exc,
    input  logic              e_bd,
    input  logic              e_is_load,
    input  logic              e_is_store,
    output logic [31:0]       m_pc,
    output logic [31:0]       m_instr,
    output logic [31:0]       m_res,
    output logic [31:0]       m_rt_data,
    output logic [4:0]        m_wa,
    output logic [TNEW_W-1:0] m_tnew,
    output logic [4:0]        m_exc,
    output logic              m_bd,
    output logic              m_is_load,
`ifdef EM_PERF_CNT_EN
    output logic [31:0]       m_perf_md,
`endif
    output logic              m_is_store
);

    logic [4:0]        mrg_exc;
    logic [4:0]        mrg_wa;
    logic              mrg_is_load;
    logic              mrg_is_store;
    logic [31:0]       sel_res;
    logic [TNEW_W-1:0] aged_tnew;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       res_q, res_d;
    logic [31:0]       rt_data_q, rt_data_d;
    logic [4:0]        wa_q, wa_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [4:0]        exc_q, exc_d;
    logic              bd_q, bd_d;
    logic              is_load_q, is_load_d;
    logic              is_store_q, is_store_d;

    em_exc_merge u_exc_merge (
        .exc_i      (e_exc),
        .alu_ov_i   (e_alu_ov),
        .is_load_i  (e_is_load),
        .is_store_i (e_is_store),
        .wa_i       (e_wa),
        .exc_o      (mrg_exc),
        .wa_o       (mrg_wa),
        .is_load_o  (mrg_is_load),
        .is_store_o (mrg_is_store)
    );

    always_comb begin
        case (e_res_sel)
            RES_MDU: sel_res = e_mdu_res;
            RES_PC8: sel_res = e_pc + 32'd8;
            default: sel_res = e_alu_res;
        endcase
        // Tnew saturates at zero so a ready result never looks pending again.
        aged_tnew = (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        res_d      = res_q;
        rt_data_d  = rt_data_q;
        wa_d       = wa_q;
        tnew_d     = tnew_q;
        exc_d      = exc_q;
        bd_d       = bd_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;

        if (req || flush) begin
            pc_d       = req ? HANDLER_PC : e_pc;
            bd_d       = req ? 1'b0 : e_bd;
            instr_d    = '0;
            res_d      = '0;
            rt_data_d  = '0;
            wa_d       = '0;
            tnew_d     = '0;
            exc_d      = EXC_NONE;
            is_load_d  = 1'b0;
            is_store_d = 1'b0;
        end else if (en) begin
            pc_d       = e_pc;
            instr_d    = e_instr;
            res_d      = sel_res;
            rt_data_d  = e_rt_data;
            wa_d       = mrg_wa;
            tnew_d     = aged_tnew;
            exc_d      = mrg_exc;
            bd_d       = e_bd;
            is_load_d  = mrg_is_load;
            is_store_d = mrg_is_store;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            instr_q    <= '0;
            res_q      <= '0;
            rt_data_q  <= '0;
            wa_q       <= '0;
            tnew_q     <= '0;
            exc_q      <= EXC_NONE;
            bd_q       <= 1'b0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            res_q      <= res_d;
            rt_data_q  <= rt_data_d;
            wa_q       <= wa_d;
            tnew_q     <= tnew_d;
            exc_q      <= exc_d;
            bd_q       <= bd_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
        end
    end

`ifdef EM_PERF_CNT_EN
    logic [31:0] perf_md_q, perf_md_d;

    // Survives req and flush so software can sample it across exceptions.
    always_comb begin
        perf_md_d = perf_md_q;
        if (!req && !flush && en && e_res_sel == RES_MDU && mrg_exc == EXC_NONE) begin
            perf_md_d = perf_md_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_md_q <= '0;
        end else begin
            perf_md_q <= perf_md_d;
        end
    end

    assign m_perf_md = perf_md_q;
`endif

    assign m_pc       = pc_q;
    assign m_instr    = instr_q;
    assign m_res      = res_q;
    assign m_rt_data  = rt_data_q;
    assign m_wa       = wa_q;
    assign m_tnew     = tnew_q;
    assign m_exc      = exc_q;
    assign m_bd       = bd_q;
    assign m_is_load  = is_load_q;
    assign m_is_store = is_store_q;

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// tb/tb_e_m_pipe_reg.sv - scoreboard bench for e_m_pipe_reg against a behavioural model
module tb_e_m_pipe_reg;

    localparam logic [31:0] HPC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  wa;
        logic [1:0]  tnew;
        logic [4:0]  exc;
        logic        bd;
        logic        ld;
        logic        st;
        logic [31:0] perf;
    } out_t;

    logic        clk;
    logic        reset, req, flush, en;
    logic [31:0] e_pc, e_instr, e_alu_res, e_mdu_res, e_rt_data;
    logic        e_alu_ov, e_bd, e_is_load, e_is_store;
    logic [1:0]  e_res_sel, e_tnew;
    logic [4:0]  e_wa, e_exc;
    logic [31:0] m_pc, m_instr, m_res, m_rt_data;
    logic [4:0]  m_wa, m_exc;
    logic [1:0]  m_tnew;
    logic        m_bd, m_is_load, m_is_store;
`ifdef EM_PERF_CNT_EN
    logic [31:0] m_perf_md;
`endif

    int   errors = 0;
    int   checks = 0;
    out_t mdl;
    out_t exp_q[$];

    e_m_pipe_reg dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .flush      (flush),
        .en         (en),
        .e_pc       (e_pc),
        .e_instr    (e_instr),
        .e_alu_res  (e_alu_res),
        .e_alu_ov   (e_alu_ov),
        .e_mdu_res  (e_mdu_res),
        .e_res_sel  (e_res_sel),
        .e_rt_data  (e_rt_data),
        .e_wa       (e_wa),
        .e_tnew     (e_tnew),
        .e_exc      (e_exc),
        .e_bd       (e_bd),
        .e_is_load  (e_is_load),
        .e_is_store (e_is_store),
        .m_pc       (m_pc),
        .m_instr    (m_instr),
        .m_res      (m_res),
        .m_rt_data  (m_rt_data),
        .m_wa       (m_wa),
        .m_tnew     (m_tnew),
        .m_exc      (m_exc),
        .m_bd       (m_bd),
        .m_is_load  (m_is_load),
`ifdef EM_PERF_CNT_EN
        .m_perf_md  (m_perf_md),
`endif
        .m_is_store (m_is_store)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: one step of the register as a whole, from the behavioural rules.
    function automatic out_t model_step(input out_t cur);
        out_t n;
        logic [4:0] code;
        n = cur;
        if (reset) begin
            n = '0;
        end else if (req) begin
            n = '0;
            n.pc = HPC;
            n.perf = cur.perf;
        end else if (flush) begin
            n = '0;
            n.pc = e_pc;
            n.bd = e_bd;
            n.perf = cur.perf;
        end else if (en) begin
            if (e_exc != 0)                    code = e_exc;
            else if (e_alu_ov && e_is_load)    code = 5'd4;
            else if (e_alu_ov && e_is_store)   code = 5'd5;
            else if (e_alu_ov)                 code = 5'd12;
            else                               code = 5'd0;
            n.pc    = e_pc;
            n.instr = e_instr;
            n.rt    = e_rt_data;
            n.bd    = e_bd;
            n.exc   = code;
            n.res   = (e_res_sel == 2'd1) ? e_mdu_res :
                      (e_res_sel == 2'd2) ? e_pc + 32'd8 : e_alu_res;
            n.tnew  = (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            n.wa    = (code != 0) ? 5'd0 : e_wa;
            n.ld    = (code != 0) ? 1'b0 : e_is_load;
            n.st    = (code != 0) ? 1'b0 : e_is_store;
            if (e_res_sel == 2'd1 && code == 0) n.perf = cur.perf + 32'd1;
        end
        return n;
    endfunction

    task automatic cyc(input logic rst, input logic rq, input logic fl, input logic ena);
        reset = rst;
        req   = rq;
        flush = fl;
        en    = ena;
        mdl   = model_step(mdl);
        exp_q.push_back(mdl);
        @(negedge clk);
    endtask

    task automatic set_data(input logic [31:0] pc, input logic [1:0] sel, input logic [31:0] alu,
                            input logic [31:0] mdu, input logic ov, input logic [4:0] exc,
                            input logic ld, input logic st, input logic [4:0] wa,
                            input logic [1:0] tnew, input logic bd);
        e_pc       = pc;
        e_res_sel  = sel;
        e_alu_res  = alu;
        e_mdu_res  = mdu;
        e_alu_ov   = ov;
        e_exc      = exc;
        e_is_load  = ld;
        e_is_store = st;
        e_wa       = wa;
        e_tnew     = tnew;
        e_bd       = bd;
        e_instr    = $urandom;
        e_rt_data  = $urandom;
    endtask

    task automatic rand_data();
        logic [31:0] pc;
        pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
        set_data(pc, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 1'($urandom));
    endtask

    // Monitor: the DUT presents a new M-stage word every cycle.
    always @(posedge clk) begin
        out_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("m_pc", m_pc, e.pc);
            chk("m_instr", m_instr, e.instr);
            chk("m_res", m_res, e.res);
            chk("m_rt_data", m_rt_data, e.rt);
            chk("m_wa", 32'(m_wa), 32'(e.wa));
            chk("m_tnew", 32'(m_tnew), 32'(e.tnew));
            chk("m_exc", 32'(m_exc), 32'(e.exc));
            chk("m_bd", 32'(m_bd), 32'(e.bd));
            chk("m_is_load", 32'(m_is_load), 32'(e.ld));
            chk("m_is_store", 32'(m_is_store), 32'(e.st));
`ifdef EM_PERF_CNT_EN
            chk("m_perf_md", m_perf_md, e.perf);
`endif
        end
    end

    initial begin
        mdl = '0;
        reset = 1'b1; req = 1'b0; flush = 1'b0; en = 1'b1;
        set_data(32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        @(negedge clk);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);

        set_data(32'h0000_1000, 2'd1, 32'h1111, 32'hDEAD_BEEF, 0, 0, 0, 0, 5'd5, 2'd2, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_3000, 2'd2, 32'h1111, 32'h2222, 0, 0, 0, 0, 5'd3, 2'd0, 0);
        cyc(0, 0, 0, 1);
        set_data(32'hFFFF_FFF8, 2'd2, 32'h1111, 32'h2222, 0, 0, 0, 0, 5'd3, 2'd1, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_3004, 2'd3, 32'h5555, 32'h2222, 0, 0, 0, 0, 5'd4, 2'd3, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_3008, 2'd0, 32'h7FFF_FFFF, 32'h0, 1, 0, 0, 1, 5'd9, 2'd1, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_300C, 2'd0, 32'h7FFF_FFFF, 32'h0, 1, 5'd10, 0, 1, 5'd9, 2'd1, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_300C, 2'd0, 32'h7FFF_FFFF, 32'h0, 1, 0, 1, 0, 5'd9, 2'd1, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_300C, 2'd0, 32'h7FFF_FFFF, 32'h0, 1, 0, 0, 0, 5'd9, 2'd1, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_3010, 2'd0, 32'h1, 32'h0, 0, 0, 1, 0, 5'd7, 2'd2, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 0);

        set_data(32'h0000_2000, 2'd0, 32'hABCD, 32'h0, 0, 0, 0, 0, 5'd6, 2'd2, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cyc(0, 0, 0, 0);
        end
        rand_data();
        cyc(1, 0, 0, 0);

        set_data(32'h0000_5000, 2'd1, 32'h0, 32'h1, 0, 0, 1, 0, 5'd2, 2'd1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_5004, 2'd1, 32'h0, 32'h2, 0, 5'd4, 1, 0, 5'd2, 2'd1, 0);
        cyc(0, 0, 0, 1);
        set_data(32'h0000_5008, 2'd1, 32'h0, 32'h3, 0, 0, 0, 0, 5'd2, 2'd1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 1, 1);

        for (int i = 0; i < 300; i++) begin
            rand_data();
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
